// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin arbiters.
package rr_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Advance a round-robin pointer with an explicit wrap so N need not be a power of two.
  function automatic int rr_next(input int ptr, input int n);
    return (ptr >= n - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: the first asserted request at or after ptr wins,
// wrapping from N-1 back to 0.
module rr_pick #(
  parameter  int N = 5,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         any,
  output logic [W-1:0] idx
);

  int cand;

  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = 0;
    for (int i = 0; i < N; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N) cand = cand - N;
      if (!any && req[W'(cand)]) begin
        any = 1'b1;
        idx = W'(cand);
      end
    end
  end

endmodule

// File: rtl/rr_port_arbiter.sv
// Round-robin arbiter sharing one downstream port among N_REQ burst requesters.
// A grant holds for a whole burst, or until MAX_BURST beats force a release.
module rr_port_arbiter
  import rr_arb_pkg::*;
#(
  parameter  int N_REQ     = 5,
  parameter  int DATA_W    = 10,
  parameter  int MAX_BURST = 16,
  localparam int ID_W      = $clog2(N_REQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req_valid,
  input  logic [DATA_W-1:0] req_data [0:N_REQ-1],
  input  logic [N_REQ-1:0]  req_last,
  output logic [N_REQ-1:0]  req_ready,
  output logic              gnt_valid,
  output logic [DATA_W-1:0] gnt_data,
  output logic              gnt_last,
  output logic [ID_W-1:0]   gnt_id,
  input  logic              gnt_ready,
  output logic              burst_err
);

  localparam int              CNT_W    = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(MAX_BURST - 1);

  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  owner_q, owner_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             burst_err_q, burst_err_d;

  logic             pick_any;
  logic [ID_W-1:0]  pick_idx;
  logic             owner_last;
  logic             at_limit;
  logic             beat;

  rr_pick #(.N(N_REQ)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      burst_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      burst_err_q <= burst_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    burst_err_d = burst_err_q;
    req_ready   = '0;
    gnt_valid   = 1'b0;
    gnt_data    = '0;
    gnt_last    = 1'b0;
    gnt_id      = '0;
    owner_last  = 1'b0;
    at_limit    = 1'b0;
    beat        = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          owner_d = pick_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        owner_last         = req_last[owner_q];
        at_limit           = (beat_cnt_q == LIMIT_CNT);
        gnt_valid          = req_valid[owner_q];
        gnt_data           = req_data[owner_q];
        gnt_id             = owner_q;
        req_ready[owner_q] = gnt_ready;
        gnt_last           = gnt_valid & (owner_last | at_limit);
        beat               = gnt_valid & gnt_ready;
        // The MAX_BURST-th beat ends the grant even without req_last and flags it.
        if (beat) begin
          if (owner_last || at_limit) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
            rr_ptr_d   = ID_W'(rr_next(int'(owner_q), N_REQ));
            if (!owner_last) burst_err_d = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign burst_err = burst_err_q;

endmodule

// File: tb/tb_rr_port_arbiter.sv
// Self-checking bench for rr_port_arbiter: directed scenarios plus a randomized
// run against a beat-counting reference model.
module tb_rr_port_arbiter;

  localparam int N_REQ     = 5;
  localparam int DATA_W    = 10;
  localparam int MAX_BURST = 16;
  localparam int ID_W      = $clog2(N_REQ);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N_REQ-1:0]  req_valid = '0;
  logic [N_REQ-1:0]  req_last = '0;
  logic [DATA_W-1:0] req_data [0:N_REQ-1];
  logic              gnt_ready = 1'b0;

  logic [N_REQ-1:0]  req_ready;
  logic              gnt_valid;
  logic [DATA_W-1:0] gnt_data;
  logic              gnt_last;
  logic [ID_W-1:0]   gnt_id;
  logic              burst_err;

  logic [N_REQ-1:0]  req_ready1;
  logic              gnt_valid1;
  logic [DATA_W-1:0] gnt_data1;
  logic              gnt_last1;
  logic [ID_W-1:0]   gnt_id1;
  logic              burst_err1;

  int vectors     = 0;
  int miscompares = 0;

  rr_port_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .gnt_valid(gnt_valid), .gnt_data(gnt_data), .gnt_last(gnt_last),
    .gnt_id(gnt_id), .gnt_ready(gnt_ready), .burst_err(burst_err)
  );

  rr_port_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .MAX_BURST(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready1), .gnt_valid(gnt_valid1), .gnt_data(gnt_data1), .gnt_last(gnt_last1),
    .gnt_id(gnt_id1), .gnt_ready(gnt_ready), .burst_err(burst_err1)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the port, how many beats it has moved, where priority starts.
  logic m_busy  = 1'b0;
  int   m_owner = 0;
  int   m_ptr   = 0;
  int   m_beats = 0;
  logic m_err   = 1'b0;

  function automatic int rr_winner(input int ptr, input logic [N_REQ-1:0] v);
    for (int k = 0; k < N_REQ; k++)
      if (v[ID_W'((ptr + k) % N_REQ)]) return (ptr + k) % N_REQ;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy  <= 1'b0;
      m_owner <= 0;
      m_ptr   <= 0;
      m_beats <= 0;
      m_err   <= 1'b0;
    end else if (!m_busy) begin
      if (rr_winner(m_ptr, req_valid) >= 0) begin
        m_busy  <= 1'b1;
        m_owner <= rr_winner(m_ptr, req_valid);
      end
    end else if (req_valid[ID_W'(m_owner)] && gnt_ready) begin
      if (req_last[ID_W'(m_owner)] || (m_beats + 1 == MAX_BURST)) begin
        m_busy  <= 1'b0;
        m_ptr   <= (m_owner + 1) % N_REQ;
        m_beats <= 0;
        if (!req_last[ID_W'(m_owner)]) m_err <= 1'b1;
      end else begin
        m_beats <= m_beats + 1;
      end
    end
  end

  function automatic logic exp_valid();
    return m_busy && req_valid[ID_W'(m_owner)];
  endfunction

  function automatic logic [N_REQ-1:0] exp_ready();
    return m_busy ? (N_REQ'(gnt_ready) << m_owner) : '0;
  endfunction

  function automatic logic exp_last();
    return exp_valid() && (req_last[ID_W'(m_owner)] || (m_beats + 1 == MAX_BURST));
  endfunction

  function automatic logic [ID_W-1:0] exp_id();
    return m_busy ? ID_W'(m_owner) : '0;
  endfunction

  task automatic idle_inputs();
    req_valid = '0;
    req_last  = '0;
    gnt_ready = 1'b0;
    for (int i = 0; i < N_REQ; i++) req_data[i] = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    #2 rst = 1'b1;
    @(negedge clk);
    req_valid = '1;
    req_last  = '1;
    gnt_ready = 1'b1;
    #1;
    vectors++; if (req_ready !== '0) begin miscompares++; $display("[TB] FAIL reset_req_ready: got %b expected 0", req_ready); end
    vectors++; if (gnt_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_gnt_valid: got %b expected 0", gnt_valid); end
    vectors++; if (gnt_last !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_gnt_last: got %b expected 0", gnt_last); end
    vectors++; if (gnt_id !== '0) begin miscompares++; $display("[TB] FAIL reset_gnt_id: got %0d expected 0", gnt_id); end
    vectors++; if (burst_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_burst_err: got %b expected 0", burst_err); end
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_single();
    logic [DATA_W-1:0] d;
    do_reset();
    req_valid = 5'b00100;
    gnt_ready = 1'b1;
    req_data[2] = DATA_W'($urandom);
    #1;
    vectors++; if (gnt_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL single_latency: got %b expected 0", gnt_valid); end
    for (int b = 1; b <= 3; b++) begin
      @(negedge clk);
      d = DATA_W'($urandom);
      req_data[2] = d;
      req_last[2] = (b == 3);
      #1;
      vectors++; if (gnt_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL single_valid b%0d: got %b expected 1", b, gnt_valid); end
      vectors++; if (gnt_id !== ID_W'(2)) begin miscompares++; $display("[TB] FAIL single_id b%0d: got %0d expected 2", b, gnt_id); end
      vectors++; if (gnt_data !== d) begin miscompares++; $display("[TB] FAIL single_data b%0d: got %h expected %h", b, gnt_data, d); end
      vectors++; if (req_ready !== 5'b00100) begin miscompares++; $display("[TB] FAIL single_ready b%0d: got %b expected 00100", b, req_ready); end
      vectors++; if (gnt_last !== logic'(b == 3)) begin miscompares++; $display("[TB] FAIL single_last b%0d: got %b expected %b", b, gnt_last, b == 3); end
    end
    @(negedge clk);
    req_valid = 5'b01100;
    req_last  = 5'b01100;
    #1;
    vectors++; if (gnt_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL single_idle_after: got %b expected 0", gnt_valid); end
    vectors++; if (gnt_id !== '0) begin miscompares++; $display("[TB] FAIL single_idle_id: got %0d expected 0", gnt_id); end
    @(negedge clk);
    #1;
    vectors++; if (gnt_id !== ID_W'(3)) begin miscompares++; $display("[TB] FAIL single_next_ptr: got %0d expected 3", gnt_id); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_all_rr();
    int order[$];
    int exp_order[6] = '{0, 1, 2, 3, 4, 0};
    do_reset();
    req_valid = '1;
    req_last  = '1;
    gnt_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      vectors++; if (gnt_valid !== logic'(c % 2)) begin miscompares++; $display("[TB] FAIL rr_bubble c%0d: got %b expected %0d", c, gnt_valid, c % 2); end
      if (gnt_valid === 1'b1) order.push_back(int'(gnt_id));
      @(negedge clk);
    end
    vectors++; if (order.size() != 6) begin miscompares++; $display("[TB] FAIL rr_grant_count: got %0d expected 6", order.size()); end
    for (int i = 0; i < 6 && i < order.size(); i++) begin
      vectors++; if (order[i] != exp_order[i]) begin miscompares++; $display("[TB] FAIL rr_order g%0d: got %0d expected %0d", i, order[i], exp_order[i]); end
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] d;
    do_reset();
    d = DATA_W'($urandom);
    req_valid   = 5'b00010;
    req_data[1] = d;
    @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      #1;
      vectors++; if (gnt_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_valid s%0d: got %b expected 1", s, gnt_valid); end
      vectors++; if (gnt_data !== d) begin miscompares++; $display("[TB] FAIL bp_data_held s%0d: got %h expected %h", s, gnt_data, d); end
      vectors++; if (req_ready !== '0) begin miscompares++; $display("[TB] FAIL bp_ready s%0d: got %b expected 0", s, req_ready); end
      vectors++; if (gnt_id !== ID_W'(1)) begin miscompares++; $display("[TB] FAIL bp_id s%0d: got %0d expected 1", s, gnt_id); end
      @(negedge clk);
    end
    // Stalled cycles must not count, so the forced release lands on the 16th real beat.
    gnt_ready = 1'b1;
    for (int b = 1; b <= MAX_BURST; b++) begin
      req_data[1] = DATA_W'($urandom);
      #1;
      vectors++; if (gnt_last !== logic'(b == MAX_BURST)) begin miscompares++; $display("[TB] FAIL bp_count b%0d: got last=%b expected %b", b, gnt_last, b == MAX_BURST); end
      @(negedge clk);
    end
    #1;
    vectors++; if (gnt_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_released: got %b expected 0", gnt_valid); end
    idle_inputs();
  endtask

  task automatic test_wrap();
    do_reset();
    req_valid = 5'b01000;
    req_last  = 5'b01000;
    gnt_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    req_valid = 5'b10001;
    req_last  = 5'b10001;
    #1;
    vectors++; if (gnt_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL wrap_idle: got %b expected 0", gnt_valid); end
    @(negedge clk);
    #1;
    vectors++; if (gnt_id !== ID_W'(4)) begin miscompares++; $display("[TB] FAIL wrap_first: got %0d expected 4", gnt_id); end
    @(negedge clk);
    @(negedge clk);
    #1;
    vectors++; if (gnt_id !== ID_W'(0)) begin miscompares++; $display("[TB] FAIL wrap_second: got %0d expected 0", gnt_id); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_timeout();
    logic [DATA_W-1:0] d;
    do_reset();
    req_valid = 5'b01000;
    gnt_ready = 1'b1;
    @(negedge clk);
    for (int b = 1; b <= MAX_BURST; b++) begin
      d = DATA_W'($urandom);
      req_data[3] = d;
      #1;
      vectors++; if (gnt_last !== logic'(b == MAX_BURST)) begin miscompares++; $display("[TB] FAIL timeout_last b%0d: got %b expected %b", b, gnt_last, b == MAX_BURST); end
      vectors++; if (gnt_data !== d) begin miscompares++; $display("[TB] FAIL timeout_data b%0d: got %h expected %h", b, gnt_data, d); end
      vectors++; if (burst_err !== 1'b0) begin miscompares++; $display("[TB] FAIL timeout_err_early b%0d: got %b expected 0", b, burst_err); end
      @(negedge clk);
    end
    req_valid = '1;
    req_last  = '1;
    #1;
    vectors++; if (burst_err !== 1'b1) begin miscompares++; $display("[TB] FAIL timeout_err: got %b expected 1", burst_err); end
    vectors++; if (gnt_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL timeout_release: got %b expected 0", gnt_valid); end
    @(negedge clk);
    #1;
    vectors++; if (gnt_id !== ID_W'(4)) begin miscompares++; $display("[TB] FAIL timeout_next: got %0d expected 4", gnt_id); end
    @(negedge clk);
    idle_inputs();
    #1;
    vectors++; if (burst_err !== 1'b1) begin miscompares++; $display("[TB] FAIL timeout_sticky: got %b expected 1", burst_err); end
  endtask

  task automatic test_reset_mid();
    req_valid = 5'b00100;
    gnt_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    vectors++; if (gnt_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL rmid_beat2: got %b expected 1", gnt_valid); end
    rst = 1'b1;
    #1;
    vectors++; if (gnt_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_valid: got %b expected 0", gnt_valid); end
    vectors++; if (req_ready !== '0) begin miscompares++; $display("[TB] FAIL rmid_ready: got %b expected 0", req_ready); end
    vectors++; if (gnt_last !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_last: got %b expected 0", gnt_last); end
    vectors++; if (gnt_id !== '0) begin miscompares++; $display("[TB] FAIL rmid_id: got %0d expected 0", gnt_id); end
    vectors++; if (burst_err !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_err: got %b expected 0", burst_err); end
    @(negedge clk);
    rst = 1'b0;
    req_valid = '1;
    req_last  = '1;
    @(negedge clk);
    #1;
    vectors++; if (gnt_id !== '0) begin miscompares++; $display("[TB] FAIL rmid_fresh: got %0d expected 0", gnt_id); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_max_burst_one();
    do_reset();
    req_valid = 5'b00010;
    gnt_ready = 1'b1;
    #1;
    vectors++; if (gnt_valid1 !== 1'b0) begin miscompares++; $display("[TB] FAIL mb1_idle: got %b expected 0", gnt_valid1); end
    @(negedge clk);
    #1;
    vectors++; if (gnt_valid1 !== 1'b1) begin miscompares++; $display("[TB] FAIL mb1_valid: got %b expected 1", gnt_valid1); end
    vectors++; if (gnt_last1 !== 1'b1) begin miscompares++; $display("[TB] FAIL mb1_last: got %b expected 1", gnt_last1); end
    vectors++; if (burst_err1 !== 1'b0) begin miscompares++; $display("[TB] FAIL mb1_err_early: got %b expected 0", burst_err1); end
    @(negedge clk);
    #1;
    vectors++; if (gnt_valid1 !== 1'b0) begin miscompares++; $display("[TB] FAIL mb1_bubble: got %b expected 0", gnt_valid1); end
    vectors++; if (burst_err1 !== 1'b1) begin miscompares++; $display("[TB] FAIL mb1_err: got %b expected 1", burst_err1); end
    @(negedge clk);
    #1;
    vectors++; if (gnt_valid1 !== 1'b1) begin miscompares++; $display("[TB] FAIL mb1_regrant: got %b expected 1", gnt_valid1); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      rst       = ($urandom_range(0, 249) == 0);
      req_valid = N_REQ'($urandom) | N_REQ'($urandom);
      for (int i = 0; i < N_REQ; i++) begin
        req_last[i] = ($urandom_range(0, 7) == 0);
        req_data[i] = DATA_W'($urandom);
      end
      gnt_ready = ($urandom_range(0, 3) != 0);
      #1;
      vectors++; if (gnt_valid !== exp_valid()) begin miscompares++; $display("[TB] FAIL rand_valid c%0d: got %b expected %b", c, gnt_valid, exp_valid()); end
      vectors++; if (gnt_id !== exp_id()) begin miscompares++; $display("[TB] FAIL rand_id c%0d: got %0d expected %0d", c, gnt_id, exp_id()); end
      vectors++; if (req_ready !== exp_ready()) begin miscompares++; $display("[TB] FAIL rand_ready c%0d: got %b expected %b", c, req_ready, exp_ready()); end
      vectors++; if (burst_err !== m_err) begin miscompares++; $display("[TB] FAIL rand_err c%0d: got %b expected %b", c, burst_err, m_err); end
      if (exp_valid()) begin
        vectors++; if (gnt_last !== exp_last()) begin miscompares++; $display("[TB] FAIL rand_last c%0d: got %b expected %b", c, gnt_last, exp_last()); end
        vectors++; if (gnt_data !== req_data[ID_W'(m_owner)]) begin miscompares++; $display("[TB] FAIL rand_data c%0d: got %h expected %h", c, gnt_data, req_data[ID_W'(m_owner)]); end
      end
      @(negedge clk);
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < N_REQ; i++) req_data[i] = '0;
    test_reset();
    test_single();
    test_all_rr();
    test_backpressure();
    test_wrap();
    test_timeout();
    test_reset_mid();
    test_max_burst_one();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
